// File: rtl/fpt_event_uart.sv
// fpt_event_uart
//   Watches the FPT core's per-sample outputs. A change in veto or attention
//   level is an event. Each event is stamped with a 4-bit sequence number,
//   queued in a small FIFO and sent to the nRF legacy relay as a 5-byte
//   8N1 UART frame: A5, {veto,attn,ovf,seq}, corr[15:8], corr[7:0], xor.
//
// Ports
//   clk_100mhz     core clock, everything on the rising edge
//   rst            synchronous active-high reset
//   sample_valid   qualifies veto_in / attention_in / correction_in
//   veto_in        veto flag
//   attention_in   attention level (2 bits)
//   correction_in  motor correction (16 bits)
//   uart_tx        serial line, idle high
//   busy           FIFO non-empty or a frame in flight
//   fifo_level     records queued and not yet taken by the serialiser
//   drop_count     saturating count of events lost to a full FIFO
//
// Input qualifier: sample_valid has no back-pressure. Every cycle with
// sample_valid=1 is one sample that is consumed on that rising edge.
module fpt_event_uart #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk_100mhz,
  input  logic                          rst,
  input  logic                          sample_valid,
  input  logic                          veto_in,
  input  logic [1:0]                    attention_in,
  input  logic [15:0]                   correction_in,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_count
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = $clog2(BAUD_DIV + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // ---------------- event detection ----------------
  logic        prev_veto;
  logic [1:0]  prev_attn;
  logic        event_fire;
  logic        ev_q;
  logic        ev_veto_q;
  logic [1:0]  ev_attn_q;
  logic [15:0] ev_corr_q;

  assign event_fire = sample_valid &&
                      ((veto_in != prev_veto) || (attention_in != prev_attn));

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      prev_veto <= 1'b0;
      prev_attn <= 2'd0;
      ev_q      <= 1'b0;
      ev_veto_q <= 1'b0;
      ev_attn_q <= 2'd0;
      ev_corr_q <= 16'd0;
    end else begin
      ev_q <= event_fire;
      if (sample_valid) begin
        prev_veto <= veto_in;
        prev_attn <= attention_in;
      end
      if (event_fire) begin
        ev_veto_q <= veto_in;
        ev_attn_q <= attention_in;
        ev_corr_q <= correction_in;
      end
    end
  end

  // ---------------- event FIFO ----------------
  // Record layout {veto, attn, ovf, seq, corr}: the top byte is byte1 of
  // the frame as-is, the low 16 bits are bytes 2 and 3.
  logic [23:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   level;
  logic [3:0]    seq;
  logic          ovf_pending;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          accept;
  logic          drop;

  assign fifo_full  = (level == (AW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (level == '0);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign accept     = ev_q && (!fifo_full || pop);
  assign drop       = ev_q && fifo_full && !pop;

  always_ff @(posedge clk_100mhz) begin
    if (!rst && accept) begin
      mem[wr_ptr] <= {ev_veto_q, ev_attn_q, ovf_pending, seq, ev_corr_q};
    end
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      seq         <= 4'd0;
      ovf_pending <= 1'b0;
      drop_count  <= 8'd0;
    end else begin
      if (accept) begin
        wr_ptr      <= wr_ptr + AW'(1);
        seq         <= seq + 4'd1;
        ovf_pending <= 1'b0;
      end
      if (drop) begin
        ovf_pending <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({accept, pop})
        2'b10:   level <= level + (AW + 1)'(1);
        2'b01:   level <= level - (AW + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  assign fifo_level = level;

  // ---------------- serialiser ----------------
  state_t        state;
  state_t        state_n;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [2:0]    byte_idx;
  logic [39:0]   frame;      // byte0 in the low byte, shifted out LSB first
  logic [23:0]   head;
  logic [7:0]    chk_byte;
  logic          bit_end;
  logic          last_byte;

  assign head      = mem[rd_ptr];
  assign chk_byte  = head[23:16] ^ head[15:8] ^ head[7:0];
  assign bit_end   = (baud_cnt == '0);
  assign last_byte = (byte_idx == 3'd4);

  // The record is popped on the edge that enters LOAD, so it leaves
  // fifo_level as soon as the serialiser owns it. For back-to-back frames
  // the final stop bit hands over one cycle early; the LOAD cycle (line
  // still high) completes that stop bit, so the next start bit follows it
  // with no gap.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_n = S_LOAD;
          pop     = 1'b1;
        end
      end
      S_LOAD:  state_n = S_START;
      S_START: if (bit_end) state_n = S_DATA;
      S_DATA:  if (bit_end && (bit_cnt == 3'd7)) state_n = S_STOP;
      S_STOP: begin
        if (last_byte && (baud_cnt == CW'(1)) && !fifo_empty) begin
          state_n = S_LOAD;
          pop     = 1'b1;
        end else if (bit_end) begin
          state_n = last_byte ? S_IDLE : S_START;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state    <= S_IDLE;
      uart_tx  <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= 3'd0;
      byte_idx <= 3'd0;
      frame    <= 40'd0;
    end else begin
      state <= state_n;
      if (pop) frame <= {chk_byte, head[7:0], head[15:8], head[23:16], 8'hA5};
      case (state)
        S_IDLE: uart_tx <= 1'b1;
        S_LOAD: begin
          uart_tx  <= 1'b0;
          baud_cnt <= CW'(BAUD_DIV - 1);
          byte_idx <= 3'd0;
        end
        S_START: begin
          if (bit_end) begin
            uart_tx  <= frame[0];
            frame    <= {1'b0, frame[39:1]};
            bit_cnt  <= 3'd0;
            baud_cnt <= CW'(BAUD_DIV - 1);
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (bit_end) begin
            baud_cnt <= CW'(BAUD_DIV - 1);
            if (bit_cnt == 3'd7) begin
              uart_tx <= 1'b1;
            end else begin
              uart_tx <= frame[0];
              frame   <= {1'b0, frame[39:1]};
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        S_STOP: begin
          if (state_n == S_LOAD) begin
            uart_tx <= 1'b1;
          end else if (bit_end) begin
            if (!last_byte) begin
              uart_tx  <= 1'b0;
              byte_idx <= byte_idx + 3'd1;
              baud_cnt <= CW'(BAUD_DIV - 1);
            end
          end else begin
            baud_cnt <= baud_cnt - CW'(1);
          end
        end
        default: uart_tx <= 1'b1;
      endcase
    end
  end

  assign busy = (state != S_IDLE) || (level != '0);

endmodule

// File: tb/tb_fpt_event_uart.sv
// Bench for fpt_event_uart, run with an 8-cycle bit time and a 4-deep FIFO.
// A line receiver decodes uart_tx and checks every byte against the
// expected-byte queue filled as events are driven.
module tb_fpt_event_uart;

  localparam int DIV       = 8;
  localparam int FRAME_CYC = 50 * DIV;

  logic        clk_100mhz = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic        veto_in = 1'b0;
  logic [1:0]  attention_in = 2'd0;
  logic [15:0] correction_in = 16'd0;
  logic        uart_tx;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [7:0]  drop_count;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int rx_starts = 0;
  logic [7:0] exp_q[$];

  fpt_event_uart #(.CLK_HZ(800), .BAUD(100), .FIFO_DEPTH(4)) dut (
    .clk_100mhz   (clk_100mhz),
    .rst          (rst),
    .sample_valid (sample_valid),
    .veto_in      (veto_in),
    .attention_in (attention_in),
    .correction_in(correction_in),
    .uart_tx      (uart_tx),
    .busy         (busy),
    .fifo_level   (fifo_level),
    .drop_count   (drop_count)
  );

  // ---------------- clock ----------------
  always #5 clk_100mhz = ~clk_100mhz;
  always @(posedge clk_100mhz) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic v, input logic [1:0] a, input logic o,
                            input logic [3:0] s, input logic [15:0] c);
    logic [7:0] b1;
    b1 = {v, a, o, s};
    exp_q.push_back(8'hA5);
    exp_q.push_back(b1);
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(b1 ^ c[15:8] ^ c[7:0]);
  endtask

  task automatic drive_sample(input logic v, input logic [1:0] a, input logic [15:0] c);
    veto_in       = v;
    attention_in  = a;
    correction_in = c;
    sample_valid  = 1'b1;
    @(posedge clk_100mhz);
    #1;
    sample_valid  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk_100mhz);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    repeat (2) @(posedge clk_100mhz);
    #1;
    while (busy !== 1'b0 && n < budget) begin
      @(posedge clk_100mhz);
      #1;
      n++;
    end
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- line receiver / scoreboard ----------------
  initial begin : rx_monitor
    logic       rx_busy;
    int         rx_cnt;
    int         k;
    logic [7:0] rx_byte;
    rx_busy = 1'b0;
    rx_cnt  = 0;
    rx_byte = 8'd0;
    forever begin
      @(negedge clk_100mhz);
      if (rst) begin
        rx_busy = 1'b0;
      end else if (!rx_busy) begin
        if (uart_tx === 1'b0) begin
          rx_busy = 1'b1;
          rx_cnt  = 0;
          rx_starts++;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt % DIV == DIV / 2) begin
          k = rx_cnt / DIV;
          if (k == 0) begin
            chk("start_bit", {31'd0, uart_tx}, 32'd0);
          end else if (k <= 8) begin
            rx_byte[k-1] = uart_tx;
          end else begin
            chk("stop_bit", {31'd0, uart_tx}, 32'd1);
            if (exp_q.size() == 0) begin
              n_cmp++;
              n_err++;
              $error("FAIL unexpected_byte: observed 0x%0h expected none", rx_byte);
            end else begin
              chk("frame_byte", {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
            end
            rx_busy = 1'b0;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : stimulus
    int n;
    int t0;
    int starts0;
    logic v;
    logic [1:0] a;
    logic [15:0] c;

    do_reset();
    chk("reset_uart_tx", {31'd0, uart_tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_fifo_level", {29'd0, fifo_level}, 32'd0);
    chk("reset_drop_count", {24'd0, drop_count}, 32'd0);

    // Single event: latency, bit time, frame length.
    push_frame(1'b1, 2'd2, 1'b0, 4'd0, 16'h1234);
    drive_sample(1'b1, 2'd2, 16'h1234);
    @(posedge clk_100mhz); #1;
    chk("lat_e1_tx_high", {31'd0, uart_tx}, 32'd1);
    chk("lat_e1_level", {29'd0, fifo_level}, 32'd1);
    @(posedge clk_100mhz); #1;
    chk("lat_e2_tx_high", {31'd0, uart_tx}, 32'd1);
    @(posedge clk_100mhz); #1;
    chk("lat_e3_tx_low", {31'd0, uart_tx}, 32'd0);
    t0 = cyc;
    n = 1;
    while (n < 100) begin
      @(posedge clk_100mhz); #1;
      if (uart_tx === 1'b0) n++;
      else break;
    end
    chk("start_bit_cycles", n, DIV);
    n = 0;
    while (busy !== 1'b0 && n < 2 * FRAME_CYC) begin
      @(posedge clk_100mhz); #1;
      n++;
    end
    chk("busy_fall_cycles", cyc - t0, FRAME_CYC);
    chk("single_frame_consumed", exp_q.size(), 0);

    // correction-only changes never fire.
    starts0 = rx_starts;
    for (int i = 0; i < 100; i++) drive_sample(1'b1, 2'd2, 16'($urandom_range(0, 65535)));
    repeat (4) @(posedge clk_100mhz); #1;
    chk("corr_only_no_start", rx_starts, starts0);
    chk("corr_only_level", {29'd0, fifo_level}, 32'd0);
    chk("corr_only_busy", {31'd0, busy}, 32'd0);

    // Overflow: 8 consecutive toggles into a 4-deep FIFO.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      v = (i % 2 == 0);
      if (i < 5) push_frame(v, 2'd0, 1'b0, 4'(i), 16'h1000 + 16'(i));
      drive_sample(v, 2'd0, 16'h1000 + 16'(i));
    end
    @(posedge clk_100mhz); #1;
    chk("ovf_drop_count", {24'd0, drop_count}, 32'd3);
    chk("ovf_level_full", {29'd0, fifo_level}, 32'd4);
    wait_idle("ovf_drain_idle", 8 * FRAME_CYC);
    push_frame(1'b1, 2'd0, 1'b1, 4'd5, 16'hAAAA);
    drive_sample(1'b1, 2'd0, 16'hAAAA);
    push_frame(1'b0, 2'd0, 1'b0, 4'd6, 16'h5555);
    drive_sample(1'b0, 2'd0, 16'h5555);
    wait_idle("ovf_after_idle", 4 * FRAME_CYC);
    chk("ovf_frames_consumed", exp_q.size(), 0);

    // 17 spaced events: sequence wraps.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      v = (i % 2 == 0);
      a = 2'($urandom_range(0, 3));
      c = 16'($urandom_range(0, 65535));
      push_frame(v, a, 1'b0, 4'(i % 16), c);
      drive_sample(v, a, c);
      wait_idle("seq_wrap_idle", 2 * FRAME_CYC);
    end
    chk("seq_frames_consumed", exp_q.size(), 0);

    // 300 drops with the FIFO held full: saturation.
    do_reset();
    for (int i = 0; i < 305; i++) begin
      v = (i % 2 == 0);
      if (i < 5) push_frame(v, 2'd0, 1'b0, 4'(i), 16'(i));
      drive_sample(v, 2'd0, 16'(i));
      if (i == 259) chk("drop_count_254", {24'd0, drop_count}, 32'd254);
    end
    @(posedge clk_100mhz); #1;
    chk("drop_count_sat", {24'd0, drop_count}, 32'd255);
    wait_idle("sat_drain_idle", 8 * FRAME_CYC);
    chk("sat_frames_consumed", exp_q.size(), 0);

    // Reset during byte2 data bits.
    do_reset();
    push_frame(1'b0, 2'd1, 1'b0, 4'd0, 16'hBEEF);
    drive_sample(1'b0, 2'd1, 16'hBEEF);
    push_frame(1'b1, 2'd1, 1'b0, 4'd1, 16'h0001);
    drive_sample(1'b1, 2'd1, 16'h0001);
    n = 0;
    while (uart_tx !== 1'b0 && n < 20) begin
      @(posedge clk_100mhz); #1;
      n++;
    end
    chk("rst_test_start_seen", {31'd0, uart_tx}, 32'd0);
    repeat (24 * DIV) @(posedge clk_100mhz);
    #1;
    chk("rst_test_level_before", {29'd0, fifo_level}, 32'd1);
    rst = 1'b1;
    @(posedge clk_100mhz); #1;
    chk("midframe_rst_tx", {31'd0, uart_tx}, 32'd1);
    chk("midframe_rst_busy", {31'd0, busy}, 32'd0);
    chk("midframe_rst_level", {29'd0, fifo_level}, 32'd0);
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk_100mhz); #1;
    push_frame(1'b1, 2'd3, 1'b0, 4'd0, 16'h5A5A);
    drive_sample(1'b1, 2'd3, 16'h5A5A);
    wait_idle("post_rst_idle", 2 * FRAME_CYC);
    repeat (4) @(posedge clk_100mhz); #1;
    chk("final_exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
